// File: rtl/wb_aes_pkg.sv
// Shared register map, control/status bit positions and dispatcher state
// encoding for the Wishbone AES stream controller.
package wb_aes_pkg;

  localparam int unsigned BLK_W = 128;

  // Word offsets as decoded from wb_adr_i[6:2]
  localparam logic [4:0] OFS_KEY0   = 5'h00;
  localparam logic [4:0] OFS_STG0   = 5'h08;
  localparam logic [4:0] OFS_STG3   = 5'h0B;
  localparam logic [4:0] OFS_OUT0   = 5'h0C;
  localparam logic [4:0] OFS_OUT3   = 5'h0F;
  localparam logic [4:0] OFS_CTRL   = 5'h10;
  localparam logic [4:0] OFS_STATUS = 5'h11;
  localparam logic [4:0] OFS_FLAGS  = 5'h12;

  localparam int unsigned CTRL_RUN     = 0;
  localparam int unsigned CTRL_DEC     = 1;
  localparam int unsigned CTRL_SIZE_LO = 2;
  localparam int unsigned CTRL_IRQ_EN  = 4;
  localparam int unsigned CTRL_SRST    = 8;

  localparam int unsigned STAT_BUSY      = 0;
  localparam int unsigned STAT_IN_FULL   = 1;
  localparam int unsigned STAT_IN_EMPTY  = 2;
  localparam int unsigned STAT_OUT_FULL  = 3;
  localparam int unsigned STAT_OUT_EMPTY = 4;
  localparam int unsigned STAT_IN_CNT    = 8;
  localparam int unsigned STAT_OUT_CNT   = 16;

  localparam int unsigned FLG_DONE    = 0;
  localparam int unsigned FLG_IN_OVF  = 1;
  localparam int unsigned FLG_OUT_UDF = 2;

  typedef enum logic [1:0] {
    DISP_IDLE = 2'd0,
    DISP_LOAD = 2'd1,
    DISP_WAIT = 2'd2
  } disp_state_e;

  function automatic logic [31:0] lane_merge(input logic [31:0] old_w,
                                             input logic [31:0] new_w,
                                             input logic [3:0]  sel);
    logic [31:0] r;
    r = old_w;
    for (int unsigned b = 0; b < 4; b++) begin
      if (sel[b]) r[8*b +: 8] = new_w[8*b +: 8];
    end
    return r;
  endfunction

endpackage

// File: rtl/aes_blk_fifo.sv
// Block FIFO with occupancy count; push while full is dropped unless a pop
// frees the slot in the same cycle, pop while empty is ignored.
module aes_blk_fifo #(
  parameter int unsigned W     = 128,
  parameter int unsigned DEPTH = 4,
  localparam int unsigned AW   = $clog2(DEPTH),
  localparam int unsigned CW   = AW + 1
) (
  input  logic          clk,
  input  logic          rst_n,
  input  logic          clr,
  input  logic          push,
  input  logic [W-1:0]  din,
  input  logic          pop,
  output logic [W-1:0]  dout,
  output logic          full,
  output logic          empty,
  output logic [CW-1:0] count
);

  logic [W-1:0]  mem_q [DEPTH];
  logic [W-1:0]  mem_d [DEPTH];
  logic [AW-1:0] wptr_q, wptr_d;
  logic [AW-1:0] rptr_q, rptr_d;
  logic [CW-1:0] count_q, count_d;
  logic          do_push, do_pop;

  assign full  = (count_q == CW'(DEPTH));
  assign empty = (count_q == '0);
  assign count = count_q;
  assign dout  = mem_q[rptr_q];

  always_comb begin
    do_pop  = pop & ~empty;
    do_push = push & (~full | do_pop);
    mem_d   = mem_q;
    if (do_push) mem_d[wptr_q] = din;
    wptr_d  = wptr_q + AW'(do_push);
    rptr_d  = rptr_q + AW'(do_pop);
    count_d = count_q + CW'(do_push) - CW'(do_pop);
  end

  always_ff @(posedge clk) begin
    mem_q <= mem_d;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wptr_q  <= '0;
      rptr_q  <= '0;
      count_q <= '0;
    end else if (clr) begin
      wptr_q  <= '0;
      rptr_q  <= '0;
      count_q <= '0;
    end else begin
      wptr_q  <= wptr_d;
      rptr_q  <= rptr_d;
      count_q <= count_d;
    end
  end

endmodule

// File: rtl/wb_aes_stream_ctrl.sv
// Wishbone-controlled AES block streamer: key/config registers, input and
// output block FIFOs, and a dispatcher feeding one block at a time to the engine.
module wb_aes_stream_ctrl
  import wb_aes_pkg::*;
#(
  parameter int unsigned KEY_W = 256,
  parameter int unsigned DEPTH = 4
) (
  input  logic               wb_clk_i,
  input  logic               wb_rst_n_i,
  input  logic [31:0]        wb_adr_i,
  input  logic [31:0]        wb_dat_i,
  input  logic [3:0]         wb_sel_i,
  input  logic               wb_we_i,
  input  logic               wb_cyc_i,
  input  logic               wb_stb_i,
  output logic               wb_ack_o,
  output logic [31:0]        wb_dat_o,
  output logic               wb_err_o,
  output logic               wb_rty_o,
  output logic [KEY_W-1:0]   key_o,
  output logic               dec_o,
  output logic [1:0]         size_o,
  output logic [BLK_W-1:0]   data_o,
  output logic               load_o,
  input  logic [BLK_W-1:0]   data_i,
  input  logic               busy_i,
  output logic               irq_o
);

  localparam int unsigned KW = KEY_W / 32;
  localparam int unsigned CW = $clog2(DEPTH) + 1;

  logic [1:0] rst_sync_q;
  logic       rst_n;

  always_ff @(posedge wb_clk_i or negedge wb_rst_n_i) begin
    if (!wb_rst_n_i) rst_sync_q <= '0;
    else             rst_sync_q <= {rst_sync_q[0], 1'b1};
  end
  assign rst_n = rst_sync_q[1];

  logic               ack_q, ack_d;
  logic [31:0]        rdata_q, rdata_d;
  logic [KEY_W-1:0]   key_q, key_d;
  logic [BLK_W-1:0]   stg_q, stg_d;
  logic               run_q, run_d;
  logic               dec_q, dec_d;
  logic [1:0]         size_q, size_d;
  logic               irq_en_q, irq_en_d;
  logic [2:0]         flags_q, flags_d;
  logic               srst_pend_q, srst_pend_d;

  disp_state_e        state_q;
  logic               load_q;
  logic [BLK_W-1:0]   data_q;
  logic               discard_q;
  logic               busy_q;

  logic               acc, wr, rd;
  logic [4:0]         ofs;
  logic [31:0]        rd_val;
  logic [31:0]        status_w;
  logic               engine_busy, cfg_lock, busy_fall, in_flight, dispatch_ok;
  logic [CW:0]        occupancy;

  logic               in_push, in_pop, in_full, in_empty;
  logic [BLK_W-1:0]   in_dout;
  logic [CW-1:0]      in_count;
  logic               out_push, out_pop, out_full, out_empty;
  logic [BLK_W-1:0]   out_dout;
  logic [CW-1:0]      out_count;

  logic               unused_adr;
  assign unused_adr = ^{wb_adr_i[31:7], wb_adr_i[1:0]};

  assign acc = wb_cyc_i & wb_stb_i & ~ack_q;
  assign wr  = acc & wb_we_i;
  assign rd  = acc & ~wb_we_i;
  assign ofs = wb_adr_i[6:2];

  assign engine_busy = load_q | busy_i;
  assign cfg_lock    = engine_busy | (in_count != '0);
  assign busy_fall   = busy_q & ~busy_i;
  assign in_flight   = (state_q != DISP_IDLE) & ~discard_q;
  assign occupancy   = {1'b0, out_count} + (CW+1)'(in_flight);
  assign dispatch_ok = run_q & ~in_empty & (occupancy < (CW+1)'(DEPTH));

  assign in_push  = wr & (ofs == OFS_STG3);
  assign in_pop   = (state_q == DISP_LOAD);
  assign out_push = (state_q == DISP_WAIT) & busy_fall & ~discard_q;
  assign out_pop  = rd & (ofs == OFS_OUT3);

  aes_blk_fifo #(.W(BLK_W), .DEPTH(DEPTH)) u_in_fifo (
    .clk   (wb_clk_i),
    .rst_n (rst_n),
    .clr   (srst_pend_q),
    .push  (in_push),
    .din   (stg_d),
    .pop   (in_pop),
    .dout  (in_dout),
    .full  (in_full),
    .empty (in_empty),
    .count (in_count)
  );

  aes_blk_fifo #(.W(BLK_W), .DEPTH(DEPTH)) u_out_fifo (
    .clk   (wb_clk_i),
    .rst_n (rst_n),
    .clr   (srst_pend_q),
    .push  (out_push),
    .din   (data_i),
    .pop   (out_pop),
    .dout  (out_dout),
    .full  (out_full),
    .empty (out_empty),
    .count (out_count)
  );

  always_comb begin
    status_w                     = '0;
    status_w[STAT_BUSY]          = engine_busy;
    status_w[STAT_IN_FULL]       = in_full;
    status_w[STAT_IN_EMPTY]      = in_empty;
    status_w[STAT_OUT_FULL]      = out_full;
    status_w[STAT_OUT_EMPTY]     = out_empty;
    status_w[STAT_IN_CNT +: 8]   = 8'(in_count);
    status_w[STAT_OUT_CNT +: 8]  = 8'(out_count);
  end

  always_comb begin
    rd_val = '0;
    for (int unsigned i = 0; i < KW; i++) begin
      if (ofs == OFS_KEY0 + 5'(i)) rd_val = key_q[KEY_W-1-32*i -: 32];
    end
    for (int unsigned j = 0; j < 4; j++) begin
      if (ofs == OFS_STG0 + 5'(j)) rd_val = stg_q[BLK_W-1-32*j -: 32];
      if (ofs == OFS_OUT0 + 5'(j) && !out_empty) rd_val = out_dout[BLK_W-1-32*j -: 32];
    end
    case (ofs)
      OFS_CTRL: begin
        rd_val[CTRL_RUN]             = run_q;
        rd_val[CTRL_DEC]             = dec_q;
        rd_val[CTRL_SIZE_LO +: 2]    = size_q;
        rd_val[CTRL_IRQ_EN]          = irq_en_q;
      end
      OFS_STATUS: rd_val = status_w;
      OFS_FLAGS:  rd_val = {29'd0, flags_q};
      default: ;
    endcase
  end

  always_comb begin
    ack_d       = acc;
    rdata_d     = rd ? rd_val : '0;
    key_d       = key_q;
    stg_d       = stg_q;
    run_d       = run_q;
    dec_d       = dec_q;
    size_d      = size_q;
    irq_en_d    = irq_en_q;
    flags_d     = flags_q;
    srst_pend_d = 1'b0;

    if (wr) begin
      for (int unsigned i = 0; i < KW; i++) begin
        if (ofs == OFS_KEY0 + 5'(i) && !cfg_lock) key_d[KEY_W-1-32*i -: 32] = wb_dat_i;
      end
      for (int unsigned j = 0; j < 4; j++) begin
        if (ofs == OFS_STG0 + 5'(j))
          stg_d[BLK_W-1-32*j -: 32] = lane_merge(stg_q[BLK_W-1-32*j -: 32], wb_dat_i, wb_sel_i);
      end
      if (ofs == OFS_CTRL) begin
        run_d       = wb_dat_i[CTRL_RUN];
        irq_en_d    = wb_dat_i[CTRL_IRQ_EN];
        srst_pend_d = wb_dat_i[CTRL_SRST];
        if (!cfg_lock) begin
          dec_d  = wb_dat_i[CTRL_DEC];
          size_d = wb_dat_i[CTRL_SIZE_LO +: 2];
        end
      end
      if (ofs == OFS_FLAGS) flags_d = flags_q & ~wb_dat_i[2:0];
    end

    // Event sets win over a same-cycle W1C so no event is lost
    if (out_push)                        flags_d[FLG_DONE]    = 1'b1;
    if (in_push && in_full && !in_pop)   flags_d[FLG_IN_OVF]  = 1'b1;
    if (out_pop && out_empty)            flags_d[FLG_OUT_UDF] = 1'b1;
  end

  always_ff @(posedge wb_clk_i or negedge rst_n) begin
    if (!rst_n) begin
      ack_q   <= 1'b0;
      rdata_q <= '0;
    end else begin
      ack_q   <= ack_d;
      rdata_q <= rdata_d;
    end
  end

  always_ff @(posedge wb_clk_i or negedge rst_n) begin
    if (!rst_n || srst_pend_q) begin
      key_q       <= '0;
      stg_q       <= '0;
      run_q       <= 1'b0;
      dec_q       <= 1'b0;
      size_q      <= '0;
      irq_en_q    <= 1'b0;
      flags_q     <= '0;
      srst_pend_q <= 1'b0;
    end else begin
      key_q       <= key_d;
      stg_q       <= stg_d;
      run_q       <= run_d;
      dec_q       <= dec_d;
      size_q      <= size_d;
      irq_en_q    <= irq_en_d;
      flags_q     <= flags_d;
      srst_pend_q <= srst_pend_d;
    end
  end

  // Soft reset keeps tracking an engine already started so its result is dropped
  always_ff @(posedge wb_clk_i or negedge rst_n) begin
    if (!rst_n) begin
      state_q   <= DISP_IDLE;
      load_q    <= 1'b0;
      data_q    <= '0;
      discard_q <= 1'b0;
      busy_q    <= 1'b0;
    end else begin
      busy_q <= busy_i;
      load_q <= 1'b0;
      if (srst_pend_q) begin
        data_q <= '0;
        if (state_q == DISP_LOAD || (state_q == DISP_WAIT && !busy_fall)) begin
          state_q   <= DISP_WAIT;
          discard_q <= 1'b1;
        end else begin
          state_q   <= DISP_IDLE;
          discard_q <= 1'b0;
        end
      end else begin
        case (state_q)
          DISP_IDLE: begin
            if (dispatch_ok) begin
              state_q <= DISP_LOAD;
              load_q  <= 1'b1;
              data_q  <= in_dout;
            end
          end
          DISP_LOAD: state_q <= DISP_WAIT;
          DISP_WAIT: begin
            if (busy_fall) begin
              state_q   <= DISP_IDLE;
              discard_q <= 1'b0;
            end
          end
          default: state_q <= DISP_IDLE;
        endcase
      end
    end
  end

  assign wb_ack_o = ack_q;
  assign wb_dat_o = rdata_q;
  assign wb_err_o = 1'b0;
  assign wb_rty_o = 1'b0;
  assign key_o    = key_q;
  assign dec_o    = dec_q;
  assign size_o   = size_q;
  assign data_o   = data_q;
  assign load_o   = load_q;
  assign irq_o    = irq_en_q & (|flags_q);

endmodule

// File: tb/tb_wb_aes_stream_ctrl.sv
// Directed bench for wb_aes_stream_ctrl with a behavioural engine that
// returns the bitwise complement of each loaded block after eng_lat cycles.
module tb_wb_aes_stream_ctrl;

  logic         clk = 1'b0;
  logic         rst_n;
  logic [31:0]  adr, dat;
  logic [3:0]   sel;
  logic         we, cyc, stb;
  logic         ack, err, rty;
  logic [31:0]  rdat;
  logic [255:0] key_o;
  logic         dec_o;
  logic [1:0]   size_o;
  logic [127:0] data_o, data_i;
  logic         load_o, busy_i, irq_o;

  int n_err = 0;
  int n_chk = 0;
  int load_cnt = 0;
  int eng_lat = 3;
  logic [127:0] eng_blk;
  logic [255:0] exp_key;
  logic [31:0]  rv;

  always #5 clk = ~clk;

  wb_aes_stream_ctrl #(.KEY_W(256), .DEPTH(4)) dut (
    .wb_clk_i   (clk),
    .wb_rst_n_i (rst_n),
    .wb_adr_i   (adr),
    .wb_dat_i   (dat),
    .wb_sel_i   (sel),
    .wb_we_i    (we),
    .wb_cyc_i   (cyc),
    .wb_stb_i   (stb),
    .wb_ack_o   (ack),
    .wb_dat_o   (rdat),
    .wb_err_o   (err),
    .wb_rty_o   (rty),
    .key_o      (key_o),
    .dec_o      (dec_o),
    .size_o     (size_o),
    .data_o     (data_o),
    .load_o     (load_o),
    .data_i     (data_i),
    .busy_i     (busy_i),
    .irq_o      (irq_o)
  );

  task automatic check(input string tag, input logic [255:0] got, input logic [255:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  task automatic wb_xfer(input logic [31:0] a, input logic [31:0] d, input logic [3:0] s,
                         input logic w, output logic [31:0] q);
    logic got_ack;
    got_ack = 1'b0;
    q = '0;
    @(posedge clk); #1;
    adr = a; dat = d; sel = s; we = w; cyc = 1'b1; stb = 1'b1;
    for (int n = 0; n < 8; n++) begin
      @(negedge clk);
      if (ack) begin
        got_ack = 1'b1;
        q = rdat;
        break;
      end
    end
    check("wb_ack", got_ack, 1'b1);
    @(posedge clk); #1;
    cyc = 1'b0; stb = 1'b0; we = 1'b0;
  endtask

  task automatic wb_wr(input logic [31:0] a, input logic [31:0] d);
    logic [31:0] q;
    wb_xfer(a, d, 4'hF, 1'b1, q);
  endtask

  task automatic rd_chk(input string tag, input logic [31:0] a, input logic [31:0] exp);
    logic [31:0] q;
    wb_xfer(a, 32'h0, 4'hF, 1'b0, q);
    check(tag, q, exp);
  endtask

  task automatic push_blk(input logic [127:0] blk);
    for (int j = 0; j < 4; j++) wb_wr(32'h20 + 4*j, blk[127-32*j -: 32]);
  endtask

  function automatic logic [127:0] mkblk(input int k);
    logic [7:0] t;
    t = 8'hB0 + 8'(k);
    return {t, 8'h00, 16'hC0DE, t, 8'h01, 16'hC0DE, t, 8'h02, 16'hC0DE, t, 8'h03, 16'hC0DE};
  endfunction

  task automatic idle(input int n);
    repeat (n) @(posedge clk);
  endtask

  // Engine model: accepts a block on load_o, stays busy eng_lat cycles
  initial begin
    busy_i = 1'b0;
    data_i = '0;
    forever begin
      @(negedge clk);
      if (load_o) begin
        eng_blk = data_o;
        load_cnt++;
        busy_i = 1'b1;
        repeat (eng_lat) @(negedge clk);
        data_i = ~eng_blk;
        busy_i = 1'b0;
      end
    end
  end

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [127:0] b0, bk;
    rst_n = 1'b0; adr = '0; dat = '0; sel = '0; we = 1'b0; cyc = 1'b0; stb = 1'b0;
    idle(3); #1;
    check("rst_ack", ack, 1'b0);
    check("rst_key", key_o, '0);
    check("rst_load", load_o, 1'b0);
    check("rst_irq", irq_o, 1'b0);
    check("err_rty", {err, rty}, 2'b00);
    rst_n = 1'b1;
    idle(4);

    rd_chk("status_rst", 32'h44, 32'h0000_0014);
    rd_chk("ctrl_rst", 32'h40, 32'h0);

    // Key programming and single-block round trip
    exp_key = '0;
    for (int i = 0; i < 8; i++) begin
      logic [31:0] w;
      w = 32'h0001_0203 + 32'h0404_0404 * i;
      wb_wr(4*i, w);
      exp_key = {exp_key[223:0], w};
    end
    check("key_o", key_o, exp_key);
    rd_chk("key_w2", 32'h08, 32'h0809_0A0B);
    wb_wr(32'h40, 32'h0D);
    check("size_o", size_o, 2'd3);
    check("dec_o", dec_o, 1'b0);
    b0 = 128'h0011_2233_4455_6677_8899_AABB_CCDD_EEFF;
    push_blk(b0);
    idle(20);
    check("load_cnt1", load_cnt, 1);
    check("data_o", eng_blk, b0);
    rd_chk("status_done", 32'h44, 32'h0001_0004);
    rd_chk("flags_done", 32'h48, 32'h1);
    check("irq_off", irq_o, 1'b0);
    rd_chk("out_w0", 32'h30, 32'hFFEE_DDCC);
    rd_chk("out_w1", 32'h34, 32'hBBAA_9988);
    rd_chk("out_w2", 32'h38, 32'h7766_5544);
    rd_chk("out_w3", 32'h3C, 32'h3322_1100);
    rd_chk("status_pop", 32'h44, 32'h0000_0014);
    wb_wr(32'h48, 32'h1);
    rd_chk("flags_clr", 32'h48, 32'h0);

    // Byte-lane write into staging
    begin
      logic [31:0] q;
      wb_xfer(32'h20, 32'hFFFF_FFFF, 4'b0101, 1'b1, q);
    end
    rd_chk("stg_lanes", 32'h20, 32'h00FF_22FF);

    // Overflow: five pushes into a four-deep input FIFO with run off
    wb_wr(32'h40, 32'h0C);
    for (int k = 0; k < 5; k++) push_blk(mkblk(k));
    rd_chk("status_ovf", 32'h44, 32'h0000_0412);
    rd_chk("flags_ovf", 32'h48, 32'h2);
    check("load_cnt_norun", load_cnt, 1);
    wb_wr(32'h00, 32'hDEAD_BEEF);
    check("key_locked", key_o, exp_key);

    // Output back-pressure: drain input into full output FIFO
    wb_wr(32'h40, 32'h0D);
    idle(60);
    check("load_cnt5", load_cnt, 5);
    rd_chk("status_outfull", 32'h44, 32'h0004_000C);
    push_blk(mkblk(5));
    push_blk(mkblk(6));
    idle(20);
    check("load_cnt_stall", load_cnt, 5);
    rd_chk("status_stall", 32'h44, 32'h0004_0208);
    bk = ~mkblk(0);
    rd_chk("pop_b0", 32'h3C, bk[31:0]);
    idle(30);
    check("load_cnt6", load_cnt, 6);
    rd_chk("status_one", 32'h44, 32'h0004_0108);
    wb_wr(32'h40, 32'h0C);
    rd_chk("flags_3", 32'h48, 32'h3);
    wb_wr(32'h48, 32'h3);
    bk = ~mkblk(1); rd_chk("pop_b1", 32'h3C, bk[31:0]);
    bk = ~mkblk(2); rd_chk("pop_b2", 32'h3C, bk[31:0]);
    bk = ~mkblk(3); rd_chk("pop_b3", 32'h3C, bk[31:0]);
    bk = ~mkblk(5); rd_chk("pop_b5", 32'h3C, bk[31:0]);
    rd_chk("status_drain", 32'h44, 32'h0000_0110);

    // Underflow with interrupt enabled
    wb_wr(32'h40, 32'h1C);
    check("irq_idle", irq_o, 1'b0);
    rd_chk("empty_w0", 32'h30, 32'h0);
    rd_chk("empty_pop", 32'h3C, 32'h0);
    rd_chk("flags_udf", 32'h48, 32'h4);
    check("irq_udf", irq_o, 1'b1);
    rd_chk("ctrl_rb", 32'h40, 32'h1C);
    rd_chk("unmapped", 32'h7C, 32'h0);

    // Soft reset while the engine holds a block
    eng_lat = 40;
    wb_wr(32'h40, 32'h1D);
    idle(6);
    check("load_cnt7", load_cnt, 7);
    wb_wr(32'h40, 32'h100);
    check("srst_key", key_o, '0);
    check("srst_size", size_o, 2'd0);
    check("srst_irq", irq_o, 1'b0);
    idle(50);
    rd_chk("srst_status", 32'h44, 32'h0000_0014);
    rd_chk("srst_flags", 32'h48, 32'h0);
    rd_chk("srst_ctrl", 32'h40, 32'h0);
    eng_lat = 3;
    wb_wr(32'h40, 32'h01);
    push_blk(mkblk(7));
    idle(20);
    check("load_cnt8", load_cnt, 8);
    rd_chk("status_after_srst", 32'h44, 32'h0001_0004);
    bk = ~mkblk(7);
    rd_chk("out_b7_w0", 32'h30, bk[127:96]);

    // Hardware reset in the middle of an access
    wb_wr(32'h00, 32'hCAFE_F00D);
    check("key_w0", key_o, {32'hCAFE_F00D, 224'd0});
    wb_wr(32'h40, 32'h11);
    rd_chk("pop_b7", 32'h3C, bk[31:0]);
    rd_chk("pop_empty2", 32'h3C, 32'h0);
    check("irq_pre", irq_o, 1'b1);
    @(posedge clk); #1;
    adr = 32'h04; dat = 32'h1234_5678; sel = 4'hF; we = 1'b1; cyc = 1'b1; stb = 1'b1;
    #2 rst_n = 1'b0;
    #1;
    check("hrst_ack", ack, 1'b0);
    check("hrst_key", key_o, '0);
    check("hrst_irq", irq_o, 1'b0);
    check("hrst_data", data_o, '0);
    check("hrst_load", load_o, 1'b0);
    @(negedge clk);
    check("hrst_noack", ack, 1'b0);
    cyc = 1'b0; stb = 1'b0; we = 1'b0;

    $display("Result: errors=%0d of %0d checks", n_err, n_chk);
    $finish;
  end

endmodule

// File: doc/wb_aes_stream_ctrl.md
WB_AES_STREAM_CTRL -- requirements
Module: wb_aes_stream_ctrl

Interface
REQ-001 SHALL have parameter KEY_W, default 256, key register width; legal values 128 or 256.
REQ-002 SHALL have parameter DEPTH, default 4, entries in each of the input and output block FIFOs; power of two, at least 2.
REQ-003 wb_clk_i  in  1  sole clock; all logic on its rising edge.
REQ-004 wb_rst_n_i  in  1  reset, asynchronous, active-low.
REQ-005 wb_adr_i in 32, wb_dat_i in 32, wb_sel_i in 4, wb_we_i in 1, wb_cyc_i in 1, wb_stb_i in 1: Wishbone classic slave inputs; only wb_adr_i[6:2] decoded.
REQ-006 wb_ack_o out 1, wb_dat_o out 32: registered ack and read data; wb_err_o, wb_rty_o out 1 each, tied 0.
REQ-007 key_o out KEY_W, dec_o out 1, size_o out 2: engine configuration.
REQ-008 data_o out 128, load_o out 1: block to engine, and its one-cycle start strobe.
REQ-009 data_i in 128, busy_i in 1: engine result, valid when busy_i falls.
REQ-010 irq_o out 1: level interrupt.

Function
REQ-011 Ack: wb_ack_o SHALL assert one cycle after cyc&stb&~ack and deassert the next cycle; every access completes in 2 cycles.
REQ-012 Map (word offset): 0x00-0x1C key words 0-7, word 0 = key MSBs; words at or beyond KEY_W/32 ignored on write, read 0.
REQ-013 0x20-0x2C input staging words 0-3 (word 0 = MSBs); byte lanes per wb_sel_i; a write to 0x2C SHALL push the complete staging block into the input FIFO.
REQ-014 0x30-0x3C output head words 0-3; a read of 0x3C SHALL pop the output FIFO head.
REQ-015 0x40 CTRL rw: bit0 run, bit1 dec, bits3:2 size, bit4 irq_en; bit8 write-1 soft reset, self-clearing, reads 0.
REQ-016 0x44 STATUS ro: bit0 engine_busy (load_o|busy_i), bit1 in_full, bit2 in_empty, bit3 out_full, bit4 out_empty, bits15:8 in_count, bits23:16 out_count.
REQ-017 0x48 FLAGS W1C: bit0 done (set per block written to output FIFO), bit1 in_overflow, bit2 out_underflow; irq_o = irq_en & |FLAGS.
REQ-018 Key, dec, size writes SHALL be ignored while engine_busy or in_count != 0.
REQ-019 Dispatcher FSM states IDLE, LOAD, WAIT: IDLE->LOAD when run & input FIFO not empty & (out_count + in_flight) < DEPTH; LOAD drives data_o = FIFO head, load_o=1 one cycle, pops input FIFO, ->WAIT; WAIT->IDLE on busy_i falling edge (registered busy_i=1, current busy_i=0), writing data_i into output FIFO.
REQ-020 Push while input FIFO full SHALL drop the block, set in_overflow, leave FIFO unchanged.
REQ-021 Read of output words while empty SHALL return 0; pop of empty FIFO sets out_underflow and leaves pointers unchanged.
REQ-022 Simultaneous push and pop on one FIFO in one cycle SHALL leave count unchanged; pointers wrap modulo DEPTH.
REQ-023 Clearing run mid-operation SHALL complete the in-flight block; no new dispatch.
REQ-024 Soft reset SHALL take effect the cycle after the write ack, equal to hardware reset except the in-flight result is discarded (WAIT ignores the next busy_i fall).
REQ-025 Unmapped reads SHALL return 0; unmapped writes no effect.

Reset
REQ-026 On wb_rst_n_i low, immediately: all outputs 0, key/staging/CTRL/FLAGS 0, FIFOs empty, FSM IDLE.
REQ-027 Deassertion SHALL be synchronised in a 2-flop chain before release of sequential logic.

Structure
REQ-028 Shared package wb_aes_pkg SHALL hold register offsets, CTRL/STATUS/FLAGS bit positions and FSM state encoding.
REQ-029 Both FIFOs SHALL be instances of one sub-module aes_blk_fifo (width 128, depth DEPTH, count output).

Verification
REQ-030 Key 000102..1F in 8 writes, CTRL=0x0D (run, size 3), push block 00112233445566778899AABBCCDDEEFF -> one load_o pulse, data_o equals block, after model busy_i falls out_count=1, FLAGS=1.
REQ-031 Run=0, push 5 blocks at DEPTH=4 -> in_count=4, in_overflow=1, 5th block absent.
REQ-032 Read 0x3C with output FIFO empty -> data 0, out_underflow=1, irq_o=1 if irq_en.
REQ-033 Fill output FIFO to 4, run=1, input holds 2 -> no load_o until a pop, then exactly one dispatch.
REQ-034 Soft reset while WAIT, then busy_i falls -> out_count stays 0, key_o=0.
REQ-035 Assert wb_rst_n_i low mid-burst -> all outputs 0 within same cycle, no ack.
